// File: rtl/tt_um_example_alu_pkg.sv
// Shared definitions for the accumulator ALU: datapath width and opcode encoding.
package tt_um_example_alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_ROR  = 3'd7
  } opcode_t;

endpackage

// File: rtl/tt_um_example_alu_if.sv
// Command/result bundle between a controller and the accumulator ALU.
interface tt_um_example_alu_if
  import tt_um_example_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             ena;
  logic             ui_in;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data;

  modport master (output ena, output ui_in, output in_data, input out_data);
  modport slave  (input ena, input ui_in, input in_data, output out_data);

endinterface

// File: rtl/tt_um_example_alu_core.sv
// Combinational ALU function y = f(op, a, b); all results wrap to WIDTH bits.
module alu4_core
  import tt_um_example_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [1:0]         sh;
  logic [2*WIDTH-1:0] rot;

  assign sh = b[1:0];
  // Rotating the doubled word right leaves the rotated value in the low half.
  assign rot = {a, a} >> sh;

  always_comb begin
    y = b;
    case (op)
      OP_PASS: y = b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << sh;
      OP_ROR:  y = rot[WIDTH-1:0];
      default: y = b;
    endcase
  end

endmodule

// File: rtl/tt_um_example_alu.sv
// Accumulator ALU: opcode-load / execute commands strobed by ena, result held in ACC.
module tt_um_example_alu
  import tt_um_example_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  tt_um_example_alu_if.slave  bus
);

  logic [1:0]       sync_reg;
  logic             rst_sync_n;
  logic [WIDTH-1:0] acc_reg, acc_next;
  opcode_t          op_reg, op_next;
  logic [WIDTH-1:0] alu_y;

  // Assertion reaches the state registers at once; release waits two clk edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
    end
  end

  assign rst_sync_n = sync_reg[1];

  alu4_core #(.WIDTH(WIDTH)) u_core (
    .op (op_reg),
    .a  (acc_reg),
    .b  (bus.in_data),
    .y  (alu_y)
  );

  always_comb begin
    acc_next = acc_reg;
    op_next  = op_reg;
    if (bus.ena) begin
      if (bus.ui_in) begin
        acc_next = alu_y;
      end else begin
        op_next = opcode_t'(bus.in_data[2:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      acc_reg <= '0;
      op_reg  <= OP_PASS;
    end else begin
      acc_reg <= acc_next;
      op_reg  <= op_next;
    end
  end

  assign bus.out_data = acc_reg;

endmodule

// File: tb/tb_tt_um_example_alu.sv
// Directed-vector bench for tt_um_example_alu with hand-computed expected results.
module tb_tt_um_example_alu;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   miss_cnt;

  tt_um_example_alu_if bus ();

  tt_um_example_alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: out_data=%b expected=%b", tag, got, exp);
    end else begin
      $display("ok   %s: out_data=%b", tag, got);
    end
  endtask

  // One command cycle: drive at the falling edge, return 1 time unit after the rising edge.
  task automatic cmd(input logic e, input logic u, input logic [3:0] d);
    @(negedge clk);
    bus.ena     = e;
    bus.ui_in   = u;
    bus.in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] d);
    cmd(1'b1, 1'b0, d);
  endtask

  task automatic exec(input logic [3:0] d);
    cmd(1'b1, 1'b1, d);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_cnt     = 0;
    miss_cnt    = 0;
    reset       = 1'b0;
    bus.ena     = 1'b0;
    bus.ui_in   = 1'b0;
    bus.in_data = 4'b0000;

    repeat (3) @(posedge clk);
    #1;
    check("reset_acc", bus.out_data, 4'b0000);
    release_reset();
    check("post_release_idle", bus.out_data, 4'b0000);

    exec(4'b1010);
    check("pass_from_reset", bus.out_data, 4'b1010);

    // bit 3 of the opcode word must be ignored
    load(4'b1001);
    check("load_keeps_acc", bus.out_data, 4'b1010);
    exec(4'b0111);
    check("add_wrap", bus.out_data, 4'b0001);

    load(4'b0010);
    exec(4'b0011);
    check("sub_borrow_wrap", bus.out_data, 4'b1110);

    cmd(1'b0, 1'b0, 4'b0101);
    check("hold_ena0_a", bus.out_data, 4'b1110);
    cmd(1'b0, 1'b1, 4'b1111);
    check("hold_ena0_b", bus.out_data, 4'b1110);
    cmd(1'b0, 1'b0, 4'b0000);
    check("hold_ena0_c", bus.out_data, 4'b1110);
    exec(4'b0001);
    check("op_held_sub", bus.out_data, 4'b1101);

    load(4'b0000);
    exec(4'b1001);
    check("pass_1001", bus.out_data, 4'b1001);
    load(4'b0111);
    exec(4'b1101);
    check("ror_by1", bus.out_data, 4'b1100);
    load(4'b0110);
    exec(4'b0111);
    check("shl_by3", bus.out_data, 4'b0000);

    load(4'b0000);
    exec(4'b1100);
    check("pass_1100", bus.out_data, 4'b1100);
    // SUB is pending when reset hits; it must be discarded
    load(4'b0010);
    cmd(1'b0, 1'b0, 4'b0000);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_clear", bus.out_data, 4'b0000);
    release_reset();
    exec(4'b0101);
    check("pass_after_reset", bus.out_data, 4'b0101);

    load(4'b0011);
    exec(4'b0110);
    check("and", bus.out_data, 4'b0100);
    load(4'b0100);
    exec(4'b0011);
    check("or", bus.out_data, 4'b0111);
    load(4'b0101);
    exec(4'b1111);
    check("xor", bus.out_data, 4'b1000);
    load(4'b0110);
    exec(4'b0100);
    check("shl_by0", bus.out_data, 4'b1000);
    load(4'b0111);
    exec(4'b1000);
    check("ror_by0", bus.out_data, 4'b1000);
    exec(4'b0010);
    check("ror_by2", bus.out_data, 4'b0010);
    exec(4'b0011);
    check("ror_by3", bus.out_data, 4'b0100);
    load(4'b0110);
    exec(4'b0001);
    check("shl_by1", bus.out_data, 4'b1000);
    load(4'b0001);
    exec(4'b1000);
    check("add_to_zero", bus.out_data, 4'b0000);

    cmd(1'b0, 1'b0, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
